// File: rtl/y86_pkg.sv
// Shared constants for the Y86-64 fetch/execute core: ALU function codes,
// condition-code bit positions and register-ID sentinel.
package y86_pkg;

    localparam logic [3:0] ALUADD = 4'h0;
    localparam logic [3:0] ALUSUB = 4'h1;
    localparam logic [3:0] ALUAND = 4'h2;
    localparam logic [3:0] ALUXOR = 4'h3;
    localparam logic [3:0] ALUOR  = 4'h4;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/y86_alu.sv
// Combinational 64-bit Y86 ALU producing the result and {ZF,SF,OF}.
// Y86_ALU_EXT_EN enables function code 4 as bitwise OR.
module y86_alu
    import y86_pkg::*;
(
    input  logic [63:0] alu_a,
    input  logic [63:0] alu_b,
    input  logic [3:0]  alufun,
    output logic [63:0] val_e,
    output logic [2:0]  new_cc
);

    logic of_next;

    always_comb begin
        val_e   = 64'h0;
        of_next = 1'b0;
        case (alufun)
            ALUADD: begin
                val_e   = alu_b + alu_a;
                of_next = (alu_a[63] == alu_b[63]) && (val_e[63] != alu_a[63]);
            end
            ALUSUB: begin
                val_e   = alu_b - alu_a;
                of_next = (alu_b[63] != alu_a[63]) && (val_e[63] != alu_b[63]);
            end
            ALUAND: val_e = alu_b & alu_a;
            ALUXOR: val_e = alu_b ^ alu_a;
`ifdef Y86_ALU_EXT_EN
            ALUOR:  val_e = alu_b | alu_a;
`endif
            default: val_e = 64'h0;
        endcase
    end

    always_comb begin
        new_cc        = 3'b000;
        new_cc[CC_ZF] = (val_e == 64'h0);
        new_cc[CC_SF] = val_e[63];
        new_cc[CC_OF] = of_next;
    end

endmodule

// File: rtl/y86_fetch_exec_core.sv
// Y86-64 instruction byte store with 10-byte fetch window and field aligner,
// plus the execute ALU and condition-code register (ALU options via Y86_ALU_EXT_EN).
module y86_fetch_exec_core
    import y86_pkg::*;
#(
    parameter int IMEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_en,
    input  logic [63:0] load_addr,
    input  logic [7:0]  load_byte,
    input  logic [63:0] f_pc,
    input  logic        need_regids,
    output logic [7:0]  f_ibyte,
    output logic [71:0] f_ibytes,
    output logic        imem_error,
    output logic [3:0]  f_rA,
    output logic [3:0]  f_rB,
    output logic [63:0] f_valC,
    input  logic [63:0] aluA,
    input  logic [63:0] aluB,
    input  logic [3:0]  alufun,
    input  logic        set_cc,
    output logic [63:0] e_valE,
    output logic [2:0]  new_cc,
    output logic [2:0]  cc
);

    localparam int AW = $clog2(IMEM_BYTES);

    logic [7:0] mem_reg [IMEM_BYTES];
    logic [7:0] fetch_bytes [10];
    logic       load_ok;
    logic [2:0] cc_reg;

    assign load_ok = load_en && ({1'b0, load_addr} < 65'(IMEM_BYTES));

    // One register per byte so reset can clear the whole store in a single edge.
    for (genvar gi = 0; gi < IMEM_BYTES; gi++) begin : g_mem
        always_ff @(posedge clock) begin
            if (reset) begin
                mem_reg[gi] <= 8'h00;
            end else if (load_ok && (load_addr[AW-1:0] == AW'(gi))) begin
                mem_reg[gi] <= load_byte;
            end
        end
    end

    // 65-bit address sum: a carry past 2^64 lands in bit 64 and reads as out of range.
    for (genvar gi = 0; gi < 10; gi++) begin : g_fetch
        logic [64:0] byte_addr;
        assign byte_addr       = {1'b0, f_pc} + 65'(gi);
        assign fetch_bytes[gi] = (byte_addr < 65'(IMEM_BYTES)) ? mem_reg[byte_addr[AW-1:0]] : 8'h00;
    end

    assign f_ibyte = fetch_bytes[0];

    for (genvar gi = 1; gi < 10; gi++) begin : g_pack
        assign f_ibytes[8*(gi-1) +: 8] = fetch_bytes[gi];
    end

    assign imem_error = (f_pc > 64'(IMEM_BYTES - 10));

    always_comb begin
        f_rA   = RNONE;
        f_rB   = RNONE;
        f_valC = f_ibytes[63:0];
        if (need_regids) begin
            f_rA   = f_ibytes[7:4];
            f_rB   = f_ibytes[3:0];
            f_valC = f_ibytes[71:8];
        end
    end

    y86_alu u_alu (
        .alu_a  (aluA),
        .alu_b  (aluB),
        .alufun (alufun),
        .val_e  (e_valE),
        .new_cc (new_cc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cc_reg <= CC_RESET;
        end else if (set_cc) begin
            cc_reg <= new_cc;
        end
    end

    assign cc = cc_reg;

endmodule

// File: tb/tb_y86_fetch_exec_core.sv
// Self-checking bench for y86_fetch_exec_core: directed steps plus randomized
// fetch/ALU traffic checked against a byte-array and signed-arithmetic model.
module tb_y86_fetch_exec_core;

    localparam int MEM = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_en;
    logic [63:0] load_addr;
    logic [7:0]  load_byte;
    logic [63:0] f_pc;
    logic        need_regids;
    logic [7:0]  f_ibyte;
    logic [71:0] f_ibytes;
    logic        imem_error;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] aluA;
    logic [63:0] aluB;
    logic [3:0]  alufun;
    logic        set_cc;
    logic [63:0] e_valE;
    logic [2:0]  new_cc;
    logic [2:0]  cc;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [MEM];
    logic [2:0] model_cc;

    y86_fetch_exec_core #(.IMEM_BYTES(MEM)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_byte   (load_byte),
        .f_pc        (f_pc),
        .need_regids (need_regids),
        .f_ibyte     (f_ibyte),
        .f_ibytes    (f_ibytes),
        .imem_error  (imem_error),
        .f_rA        (f_rA),
        .f_rB        (f_rB),
        .f_valC      (f_valC),
        .aluA        (aluA),
        .aluB        (aluB),
        .alufun      (alufun),
        .set_cc      (set_cc),
        .e_valE      (e_valE),
        .new_cc      (new_cc),
        .cc          (cc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_model();
        for (int i = 0; i < MEM; i++) model_mem[i] = 8'h00;
        model_cc = 3'b100;
    endtask

    task automatic load(input logic [63:0] addr, input logic [7:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_byte = data;
        tick();
        load_en = 1'b0;
        if (addr < 64'(MEM)) model_mem[addr[9:0]] = data;
    endtask

    function automatic logic [7:0] model_byte(input logic [63:0] pc, input int k);
        logic [64:0] a;
        a = {1'b0, pc} + 65'(k);
        if (a >= 65'(MEM)) return 8'h00;
        return model_mem[a[9:0]];
    endfunction

    task automatic check_fetch(input string tag);
        logic [71:0] exp_bytes;
        logic        exp_err;
        logic [64:0] a;
        exp_err = 1'b0;
        for (int k = 0; k < 10; k++) begin
            a = {1'b0, f_pc} + 65'(k);
            if (a >= 65'(MEM)) exp_err = 1'b1;
        end
        for (int k = 1; k < 10; k++) exp_bytes[8*(k-1) +: 8] = model_byte(f_pc, k);
        #1;
        $display("fetch %s pc=%h nr=%0d ibyte=%h err=%0d rA=%h rB=%h valC=%h",
                 tag, f_pc, need_regids, f_ibyte, imem_error, f_rA, f_rB, f_valC);
        chk({tag, ".ibyte"}, 72'(f_ibyte), 72'(model_byte(f_pc, 0)));
        chk({tag, ".ibytes"}, f_ibytes, exp_bytes);
        chk({tag, ".err"}, 72'(imem_error), 72'(exp_err));
        if (need_regids) begin
            chk({tag, ".rA"}, 72'(f_rA), 72'(exp_bytes[7:4]));
            chk({tag, ".rB"}, 72'(f_rB), 72'(exp_bytes[3:0]));
            chk({tag, ".valC"}, 72'(f_valC), 72'(exp_bytes[71:8]));
        end else begin
            chk({tag, ".rA"}, 72'(f_rA), 72'(4'hF));
            chk({tag, ".rB"}, 72'(f_rB), 72'(4'hF));
            chk({tag, ".valC"}, 72'(f_valC), 72'(exp_bytes[63:0]));
        end
    endtask

    // Reference ALU: signed 65-bit arithmetic, overflow when the true result
    // does not fit in 64 signed bits.
    function automatic logic [66:0] model_alu(input logic [63:0] a, input logic [63:0] b,
                                              input logic [3:0] fun);
        logic signed [64:0] sa, sb, wide;
        logic [63:0] val;
        logic        of;
        sa = {a[63], a};
        sb = {b[63], b};
        wide = '0;
        of = 1'b0;
        case (fun)
            4'd0: begin wide = sb + sa; of = (wide[64] != wide[63]); end
            4'd1: begin wide = sb - sa; of = (wide[64] != wide[63]); end
            4'd2: wide = {1'b0, a & b};
            4'd3: wide = {1'b0, a ^ b};
`ifdef Y86_ALU_EXT_EN
            4'd4: wide = {1'b0, a | b};
`endif
            default: wide = '0;
        endcase
        val = wide[63:0];
        return {val, (val == 64'h0), val[63], of};
    endfunction

    task automatic check_alu(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic [3:0] fun);
        logic [66:0] exp;
        aluA = a;
        aluB = b;
        alufun = fun;
        exp = model_alu(a, b, fun);
        #1;
        $display("alu %s fun=%0d A=%h B=%h valE=%h cc=%b", tag, fun, a, b, e_valE, new_cc);
        chk({tag, ".valE"}, 72'(e_valE), 72'(exp[66:3]));
        chk({tag, ".new_cc"}, 72'(new_cc), 72'(exp[2:0]));
    endtask

    initial begin
        logic [7:0] prog0 [10];
        logic [7:0] prog1 [9];
        prog0 = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        prog1 = '{8'h70, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_byte = '0;
        f_pc = '0; need_regids = 1'b0; aluA = '0; aluB = '0; alufun = '0; set_cc = 1'b0;
        clear_model();
        @(negedge clock);
        tick();
        tick();
        reset = 1'b0;

        // Post-reset state
        #1;
        chk("rst.cc", 72'(cc), 72'(3'b100));
        chk("rst.ibyte", 72'(f_ibyte), 72'(8'h00));
        chk("rst.rA", 72'(f_rA), 72'(4'hF));
        chk("rst.valC", 72'(f_valC), 72'(64'h0));
        chk("rst.err", 72'(imem_error), 72'(1'b0));
        @(negedge clock);

        // irmovq $10,%rdx at 0
        for (int i = 0; i < 10; i++) load(64'(i), prog0[i]);
        f_pc = 64'h0; need_regids = 1'b1;
        #1;
        chk("irmovq.ibyte", 72'(f_ibyte), 72'(8'h30));
        chk("irmovq.rA", 72'(f_rA), 72'(4'hF));
        chk("irmovq.rB", 72'(f_rB), 72'(4'h2));
        chk("irmovq.valC", 72'(f_valC), 72'(64'd10));
        chk("irmovq.err", 72'(imem_error), 72'(1'b0));
        @(negedge clock);

        // jmp 0x1234 at 0x20
        for (int i = 0; i < 9; i++) load(64'h20 + 64'(i), prog1[i]);
        f_pc = 64'h20; need_regids = 1'b0;
        #1;
        chk("jmp.valC", 72'(f_valC), 72'(64'h1234));
        chk("jmp.rA", 72'(f_rA), 72'(4'hF));
        chk("jmp.rB", 72'(f_rB), 72'(4'hF));
        @(negedge clock);

        // Boundary PCs; put nonzero bytes near the top of memory first
        for (int i = 1010; i < 1024; i++) load(64'(i), 8'(i));
        load(64'd1024, 8'hAA);
        load(64'hFFFF_FFFF_FFFF_FFFF, 8'h55);
        f_pc = 64'd1014; #1;
        chk("pc1014.err", 72'(imem_error), 72'(1'b0));
        @(negedge clock);
        f_pc = 64'd1015; #1;
        chk("pc1015.err", 72'(imem_error), 72'(1'b1));
        chk("pc1015.b9", 72'(f_ibytes[71:64]), 72'(8'h00));
        chk("pc1015.b8", 72'(f_ibytes[63:56]), 72'(8'hFF));
        @(negedge clock);
        f_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
        chk("pcwrap.err", 72'(imem_error), 72'(1'b1));
        chk("pcwrap.ibytes", f_ibytes, 72'h0);
        @(negedge clock);
        f_pc = 64'd1024; #1;
        chk("pc1024.ibyte", 72'(f_ibyte), 72'(8'h00));
        @(negedge clock);

        // Directed ALU cases
        check_alu("add_ovf", 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'd0);
        chk("add_ovf.spec_val", 72'(e_valE), 72'(64'h8000_0000_0000_0000));
        chk("add_ovf.spec_cc", 72'(new_cc), 72'(3'b011));
        @(negedge clock);
        check_alu("sub_eq", 64'd5, 64'd5, 4'd1);
        chk("sub_eq.spec_cc", 72'(new_cc), 72'(3'b100));
        @(negedge clock);
        check_alu("and", 64'h0F, 64'hF0, 4'd2);
        chk("and.spec_zf", 72'(new_cc[2]), 72'(1'b1));
        @(negedge clock);
        check_alu("xor", 64'h0F, 64'hFF, 4'd3);
        chk("xor.spec_val", 72'(e_valE), 72'(64'hF0));
        @(negedge clock);
        check_alu("fun4", 64'h0F, 64'hF0, 4'd4);
`ifdef Y86_ALU_EXT_EN
        chk("fun4.spec_val", 72'(e_valE), 72'(64'hFF));
`else
        chk("fun4.spec_val", 72'(e_valE), 72'(64'h0));
        chk("fun4.spec_cc", 72'(new_cc), 72'(3'b100));
`endif
        @(negedge clock);

        // set_cc on -1 + 0
        aluA = 64'hFFFF_FFFF_FFFF_FFFF; aluB = 64'h0; alufun = 4'd0; set_cc = 1'b1;
        tick();
        set_cc = 1'b0;
        model_cc = 3'b010;
        #1;
        chk("setcc.cc", 72'(cc), 72'(3'b010));
        @(negedge clock);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic [63:0] addr;
            case ($urandom_range(0, 2))
                0: addr = 64'($urandom_range(0, MEM - 1));
                1: addr = 64'($urandom_range(MEM - 16, MEM + 16));
                default: addr = {$urandom, $urandom};
            endcase
            load(addr, 8'($urandom));
        end
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: f_pc = 64'($urandom_range(0, MEM - 1));
                1: f_pc = 64'($urandom_range(MEM - 16, MEM + 4));
                2: f_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: f_pc = {$urandom, $urandom};
            endcase
            need_regids = 1'($urandom);
            check_fetch($sformatf("rnd%0d", n));
            @(negedge clock);
        end
        for (int n = 0; n < 80; n++) begin
            logic [63:0] a, b;
            logic [66:0] exp;
            logic [3:0]  fun;
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = {1'b0, 63'($urandom)} | 64'h7FFF_FFF0_0000_0000;
            fun = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
            check_alu($sformatf("ralu%0d", n), a, b, fun);
            exp = model_alu(a, b, fun);
            set_cc = 1'($urandom);
            if (set_cc) model_cc = exp[2:0];
            tick();
            set_cc = 1'b0;
            #1;
            chk($sformatf("ralu%0d.cc", n), 72'(cc), 72'(model_cc));
            @(negedge clock);
        end

        // Mid-sequence reset with load/set_cc also asserted: both are ignored
        f_pc = 64'h0;
        aluA = 64'h1; aluB = 64'h1; alufun = 4'd0;
        reset = 1'b1; load_en = 1'b1; load_addr = 64'h0; load_byte = 8'h77; set_cc = 1'b1;
        tick();
        reset = 1'b0; load_en = 1'b0; set_cc = 1'b0;
        clear_model();
        #1;
        chk("midrst.cc", 72'(cc), 72'(3'b100));
        chk("midrst.ibyte", 72'(f_ibyte), 72'(8'h00));
        @(negedge clock);
        need_regids = 1'b1;
        check_fetch("midrst0");
        @(negedge clock);
        f_pc = 64'd1012;
        check_fetch("midrst1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
